// File: rtl/reg_writeback_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : reg_writeback_unit_if                                   |
// | Brief    : Bus bundle between the CPU pipeline and the register    |
// |            file write-side front end.                              |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
interface reg_writeback_unit_if #(
    parameter int DATA_W = 32
);
    // ALU result path
    logic              alu_valid;
    logic [4:0]        alu_dr;
    logic [DATA_W-1:0] alu_data;

    // Load completion path (valid/ready)
    logic              ld_valid;
    logic              ld_ready;
    logic [4:0]        ld_dr;
    logic [DATA_W-1:0] ld_data;

    // Load issue and decode hazard check
    logic              issue_valid;
    logic [4:0]        issue_dr;
    logic [4:0]        chk_sr1;
    logic [4:0]        chk_sr2;
    logic              hazard;

    // Drain control
    logic              flush_req;
    logic              flush_done;

    // Register file write port
    logic              RegW;
    logic [4:0]        DR;
    logic [DATA_W-1:0] data_write;

    // Pipeline side: drives requests, observes write port and status
    modport master (
        output alu_valid, alu_dr, alu_data,
        output ld_valid, ld_dr, ld_data,
        output issue_valid, issue_dr, chk_sr1, chk_sr2,
        output flush_req,
        input  ld_ready, hazard, flush_done,
        input  RegW, DR, data_write
    );

    // Write-back unit side
    modport slave (
        input  alu_valid, alu_dr, alu_data,
        input  ld_valid, ld_dr, ld_data,
        input  issue_valid, issue_dr, chk_sr1, chk_sr2,
        input  flush_req,
        output ld_ready, hazard, flush_done,
        output RegW, DR, data_write
    );
endinterface
`default_nettype wire

// File: rtl/reg_writeback_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : reg_writeback_unit                                      |
// | Brief    : Serialises ALU results and queued load completions into |
// |            one register-file write per cycle, tracks pending loads |
// |            for load-use hazards and supports a queue drain.        |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module reg_writeback_unit #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int AW     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    reg_writeback_unit_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_NORMAL = 1'b0,
        ST_DRAIN  = 1'b1
    } state_t;

    localparam logic [AW:0] c_depth     = (AW+1)'(DEPTH);
    localparam logic [AW:0] c_count_one = (AW+1)'(1);

    // Load-completion FIFO
    logic [4:0]        r_fifo_dr   [DEPTH];
    logic [DATA_W-1:0] r_fifo_data [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;

    // Scoreboard of registers awaiting load data
    logic [31:0]       r_pending;

    // Drain FSM
    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_flush_done_nxt;
    logic              r_flush_done;

    // Registered write port
    logic              r_reg_w;
    logic [4:0]        r_dr;
    logic [DATA_W-1:0] r_data_write;

    // Arbitration and handshake terms
    logic              w_ld_ready;
    logic              w_push;
    logic              w_fifo_empty;
    logic              w_alu_win;
    logic              w_pop;
    logic              w_ld_win;
    logic [4:0]        w_head_dr;
    logic [DATA_W-1:0] w_head_data;

    // Acceptance depends only on registered state so ld_ready never
    // combinationally follows ld_valid.
    assign w_ld_ready   = (r_count != c_depth) && (r_state == ST_NORMAL);
    assign w_push       = bus.ld_valid && w_ld_ready;
    assign w_fifo_empty = (r_count == '0);

    // ALU results win the write slot; a write aimed at $zero frees the
    // slot for the FIFO head instead.
    assign w_alu_win   = bus.alu_valid && (bus.alu_dr != 5'd0);
    assign w_pop       = !w_alu_win && !w_fifo_empty;
    assign w_head_dr   = r_fifo_dr[r_rd_ptr];
    assign w_head_data = r_fifo_data[r_rd_ptr];
    // A popped load targeting $zero is consumed but never written.
    assign w_ld_win    = w_pop && (w_head_dr != 5'd0);

    // FIFO storage: written on push, no reset needed for the payload
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_dr[r_wr_ptr]   <= bus.ld_dr;
            r_fifo_data[r_wr_ptr] <= bus.ld_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_count_one;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_count_one;
            end
        end
    end

    // Scoreboard: clear on load write-back, set on issue (set applied last so it wins)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            if (w_ld_win) begin
                r_pending[w_head_dr] <= 1'b0;
            end
            if (bus.issue_valid && (bus.issue_dr != 5'd0)) begin
                r_pending[bus.issue_dr] <= 1'b1;
            end
        end
    end

    // Write port register: DR/data hold their last values on idle cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg_w      <= 1'b0;
            r_dr         <= 5'd0;
            r_data_write <= '0;
        end else begin
            r_reg_w <= w_alu_win || w_ld_win;
            if (w_alu_win) begin
                r_dr         <= bus.alu_dr;
                r_data_write <= bus.alu_data;
            end else if (w_ld_win) begin
                r_dr         <= w_head_dr;
                r_data_write <= w_head_data;
            end
        end
    end

    // Drain FSM state and flush_done pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_NORMAL;
            r_flush_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_flush_done <= w_flush_done_nxt;
        end
    end

    // Drain FSM next state; done coincides with the last drained write
    always_comb begin
        w_state_nxt      = r_state;
        w_flush_done_nxt = 1'b0;
        case (r_state)
            ST_NORMAL: begin
                if (bus.flush_req) begin
                    if (w_fifo_empty) begin
                        w_flush_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // No pushes while draining, so a pop from count 1 empties it.
                if (w_fifo_empty || (w_pop && (r_count == c_count_one))) begin
                    w_flush_done_nxt = 1'b1;
                    w_state_nxt      = ST_NORMAL;
                end
            end
            default: begin
                w_state_nxt = ST_NORMAL;
            end
        endcase
    end

    assign bus.ld_ready   = w_ld_ready;
    assign bus.flush_done = r_flush_done;
    assign bus.RegW       = r_reg_w;
    assign bus.DR         = r_dr;
    assign bus.data_write = r_data_write;
    assign bus.hazard     = ((bus.chk_sr1 != 5'd0) && r_pending[bus.chk_sr1]) ||
                            ((bus.chk_sr2 != 5'd0) && r_pending[bus.chk_sr2]);

endmodule
`default_nettype wire

// File: tb/tb_reg_writeback_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_reg_writeback_unit                                   |
// | Brief    : Directed self-checking bench for reg_writeback_unit.    |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tb_reg_writeback_unit;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    int   k;

    reg_writeback_unit_if #(.DATA_W(32)) bus ();

    reg_writeback_unit #(
        .DATA_W (32),
        .DEPTH  (4),
        .AW     (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 100 MHz-style free-running clock
    always #5 clk = ~clk;

    // Upstream must never issue a load to a register that is still pending
    always @(posedge clk) begin
        if (!rst && bus.issue_valid && (bus.issue_dr != 5'd0) && dut.r_pending[bus.issue_dr]) begin
            $error("issue to already-pending register %0d", bus.issue_dr);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_wr(input string tag, input logic w, input logic [4:0] d, input logic [31:0] data);
        check_eq({tag, ".RegW"}, 32'(bus.RegW), 32'(w));
        check_eq({tag, ".DR"}, 32'(bus.DR), 32'(d));
        check_eq({tag, ".data"}, bus.data_write, data);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst             = 1'b1;
        bus.alu_valid   = 1'b0;
        bus.alu_dr      = 5'd0;
        bus.alu_data    = 32'd0;
        bus.ld_valid    = 1'b0;
        bus.ld_dr       = 5'd0;
        bus.ld_data     = 32'd0;
        bus.issue_valid = 1'b0;
        bus.issue_dr    = 5'd0;
        bus.chk_sr1     = 5'd0;
        bus.chk_sr2     = 5'd0;
        bus.flush_req   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        // Reset state
        check_wr("reset", 1'b0, 5'd0, 32'd0);
        check_eq("reset.flush_done", 32'(bus.flush_done), 32'd0);
        check_eq("reset.ld_ready", 32'(bus.ld_ready), 32'd1);
        check_eq("reset.hazard", 32'(bus.hazard), 32'd0);

        // ALU write, latency 1
        bus.alu_valid = 1'b1; bus.alu_dr = 5'd5; bus.alu_data = 32'hDEADBEEF;
        tick();
        check_wr("alu5", 1'b1, 5'd5, 32'hDEADBEEF);
        // Reset mid-stream clears the write port
        bus.alu_dr = 5'd7; bus.alu_data = 32'h77; rst = 1'b1;
        tick();
        check_wr("rst_mid", 1'b0, 5'd0, 32'd0);
        rst = 1'b0; bus.alu_valid = 1'b0;
        tick();

        // Scoreboard set, load write-back clears it
        bus.issue_valid = 1'b1; bus.issue_dr = 5'd8;
        tick();
        bus.issue_valid = 1'b0; bus.chk_sr1 = 5'd8;
        #1 check_eq("hazard_set", 32'(bus.hazard), 32'd1);
        bus.ld_valid = 1'b1; bus.ld_dr = 5'd8; bus.ld_data = 32'h1234;
        tick();
        bus.ld_valid = 1'b0;
        check_wr("ld8_push", 1'b0, 5'd0, 32'd0);
        check_eq("hazard_held", 32'(bus.hazard), 32'd1);
        tick();
        check_wr("ld8_write", 1'b1, 5'd8, 32'h1234);
        check_eq("hazard_clr", 32'(bus.hazard), 32'd0);
        bus.chk_sr1 = 5'd0;
        tick();
        check_wr("ld8_idle", 1'b0, 5'd8, 32'h1234);

        // ALU busy for 6 cycles while 5 loads are offered
        k = 0;
        bus.ld_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.alu_valid = 1'b1; bus.alu_dr = 5'(10 + i); bus.alu_data = 32'(100 + i);
            bus.ld_dr = 5'(20 + k); bus.ld_data = 32'(32'hA0 + k);
            #1 check_eq("ld_ready_busy", 32'(bus.ld_ready), 32'(k < 4));
            if (k < 4) k++;
            tick();
            check_wr("alu_busy", 1'b1, 5'(10 + i), 32'(100 + i));
        end
        bus.alu_valid = 1'b0;
        for (int j = 0; j < 5; j++) begin
            #1;
            if (j == 0) check_eq("ld_ready_full", 32'(bus.ld_ready), 32'd0);
            if (j == 1) check_eq("ld_ready_freed", 32'(bus.ld_ready), 32'd1);
            tick();
            if (j == 1) bus.ld_valid = 1'b0;
            check_wr("fifo_order", 1'b1, 5'(20 + j), 32'(32'hA0 + j));
        end
        tick();
        check_wr("fifo_empty", 1'b0, 5'd24, 32'hA4);

        // ALU write to $zero yields the slot to a queued load
        bus.ld_valid = 1'b1; bus.ld_dr = 5'd3; bus.ld_data = 32'h33;
        tick();
        bus.ld_valid = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_dr = 5'd0; bus.alu_data = 32'hBAD;
        tick();
        check_wr("alu0_ld3", 1'b1, 5'd3, 32'h33);
        tick();
        check_wr("alu0_drop", 1'b0, 5'd3, 32'h33);
        bus.alu_valid = 1'b0;
        // Load to $zero pops silently
        bus.ld_valid = 1'b1; bus.ld_dr = 5'd0; bus.ld_data = 32'h55;
        tick();
        bus.ld_valid = 1'b0;
        tick();
        check_wr("ld0_drop", 1'b0, 5'd3, 32'h33);

        // Same-cycle issue and pop on DR=9: set wins
        bus.ld_valid = 1'b1; bus.ld_dr = 5'd9; bus.ld_data = 32'h99;
        tick();
        bus.ld_valid = 1'b0;
        bus.issue_valid = 1'b1; bus.issue_dr = 5'd9;
        tick();
        bus.issue_valid = 1'b0; bus.chk_sr2 = 5'd9;
        check_wr("ld9_pop", 1'b1, 5'd9, 32'h99);
        #1 check_eq("hazard_set_wins", 32'(bus.hazard), 32'd1);
        bus.ld_valid = 1'b1; bus.ld_dr = 5'd9; bus.ld_data = 32'h98;
        tick();
        bus.ld_valid = 1'b0;
        tick();
        check_wr("ld9_final", 1'b1, 5'd9, 32'h98);
        check_eq("hazard9_clr", 32'(bus.hazard), 32'd0);
        bus.chk_sr2 = 5'd0;

        // Drain with three queued loads
        for (int c = 0; c < 3; c++) begin
            bus.alu_valid = 1'b1; bus.alu_dr = 5'd1; bus.alu_data = 32'd1;
            bus.ld_valid = 1'b1; bus.ld_dr = 5'(11 + c); bus.ld_data = 32'(32'hC000 + c);
            tick();
        end
        bus.ld_valid = 1'b0; bus.flush_req = 1'b1;
        tick();
        check_eq("drain_enter.done", 32'(bus.flush_done), 32'd0);
        bus.flush_req = 1'b0; bus.alu_valid = 1'b0;
        bus.ld_valid = 1'b1; bus.ld_dr = 5'd30; bus.ld_data = 32'hEE;
        for (int j = 0; j < 3; j++) begin
            #1 check_eq("drain.ld_ready", 32'(bus.ld_ready), 32'd0);
            tick();
            check_wr("drain_wr", 1'b1, 5'(11 + j), 32'(32'hC000 + j));
            check_eq("drain.flush_done", 32'(bus.flush_done), 32'(j == 2));
        end
        bus.ld_valid = 1'b0;
        #1 check_eq("drain_exit.ld_ready", 32'(bus.ld_ready), 32'd1);
        tick();
        check_wr("drain_after", 1'b0, 5'd13, 32'hC002);
        check_eq("drain_after.done", 32'(bus.flush_done), 32'd0);

        // Flush with empty FIFO
        bus.flush_req = 1'b1;
        tick();
        check_eq("flush_empty.done", 32'(bus.flush_done), 32'd1);
        bus.flush_req = 1'b0;
        tick();
        check_eq("flush_empty.pulse", 32'(bus.flush_done), 32'd0);

        // Reset during drain discards queued loads
        for (int c = 0; c < 2; c++) begin
            bus.alu_valid = 1'b1; bus.alu_dr = 5'd2; bus.alu_data = 32'd2;
            bus.ld_valid = 1'b1; bus.ld_dr = 5'(14 + c); bus.ld_data = 32'(32'hE000 + c);
            tick();
        end
        bus.ld_valid = 1'b0; bus.flush_req = 1'b1;
        tick();
        bus.flush_req = 1'b0; bus.alu_valid = 1'b0; rst = 1'b1;
        tick();
        check_wr("rst_drain", 1'b0, 5'd0, 32'd0);
        check_eq("rst_drain.done", 32'(bus.flush_done), 32'd0);
        rst = 1'b0;
        #1 check_eq("rst_drain.ld_ready", 32'(bus.ld_ready), 32'd1);
        tick();
        check_wr("rst_drain_after", 1'b0, 5'd0, 32'd0);
        check_eq("rst_drain_after.done", 32'(bus.flush_done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
